// File: rtl/keypad_debounce_scan.sv
// 3-column x 4-row keypad scanner with frame-level ghost rejection and debounce.
// Emits a single-cycle key_valid per qualified press; key_held tracks the key until release.
module keypad_debounce_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = ($clog2(DEBOUNCE_CNT + 1) > 3) ? $clog2(DEBOUNCE_CNT + 1) : 3;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div;
    logic [1:0]       acc_hits;
    logic [3:0]       acc_code;
    logic [3:0]       cand, cand_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0]       code_nxt;
    logic             valid_nxt;

    logic             sample_tick, frame_end, frame_key;
    logic [1:0]       col_idx, sample_hits, frame_hits;
    logic [2:0]       row_bits, hit_sum;
    logic [3:0]       sample_code, frame_code;

    assign sample_tick = (div == DIV_LAST);
    assign frame_end   = sample_tick & key_col[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div     <= '0;
            key_col <= 3'b001;
        end else if (sample_tick) begin
            div     <= '0;
            key_col <= {key_col[1:0], key_col[2]};
        end else begin
            div     <= div + 1'b1;
        end
    end

    // Decode the current column sample; code only matters when exactly one row is set.
    always_comb begin
        col_idx     = key_col[1] ? 2'd1 : (key_col[2] ? 2'd2 : 2'd0);
        row_bits    = {2'b00, key_row[0]} + {2'b00, key_row[1]}
                    + {2'b00, key_row[2]} + {2'b00, key_row[3]};
        sample_hits = (row_bits >= 3'd2) ? 2'd2 : row_bits[1:0];
        sample_code = 4'd0;
        if (key_row[0])      sample_code = 4'd1 + {2'b00, col_idx};
        else if (key_row[1]) sample_code = 4'd4 + {2'b00, col_idx};
        else if (key_row[2]) sample_code = 4'd7 + {2'b00, col_idx};
        else if (key_row[3]) begin
            case (col_idx)
                2'd0:    sample_code = 4'd10;
                2'd1:    sample_code = 4'd0;
                default: sample_code = 4'd11;
            endcase
        end
        hit_sum    = {1'b0, acc_hits} + {1'b0, sample_hits};
        frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        frame_key  = (frame_hits == 2'd1);
        frame_code = (acc_hits == 2'd1) ? acc_code : sample_code;
    end

    // Hit count saturates at 2 so any multi-key frame classifies as NONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hits <= '0;
            acc_code <= '0;
        end else if (frame_end) begin
            acc_hits <= '0;
            acc_code <= '0;
        end else if (sample_tick) begin
            acc_hits <= frame_hits;
            acc_code <= frame_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
        end
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        code_nxt  = key_code;
        valid_nxt = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (frame_key) begin
                        if (DEBOUNCE_CNT == 1) begin
                            state_nxt = PRESSED;
                            code_nxt  = frame_code;
                            valid_nxt = 1'b1;
                        end else begin
                            state_nxt = DEBOUNCE;
                            cand_nxt  = frame_code;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!frame_key) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (frame_code == cand) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_TARGET) begin
                            state_nxt = PRESSED;
                            code_nxt  = cand;
                            valid_nxt = 1'b1;
                        end
                    end else begin
                        cand_nxt = frame_code;
                        cnt_nxt  = CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!frame_key) begin
                        if (DEBOUNCE_CNT == 1) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = RELEASE;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (frame_key) begin
                        state_nxt = PRESSED;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_TARGET) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        key_held = (state == PRESSED) || (state == RELEASE);
    end

endmodule

// File: tb/tb_keypad_debounce_scan.sv
// Directed bench for keypad_debounce_scan with a behavioural keypad matrix model.
// SCAN_DIV=4, DEBOUNCE_CNT=3, so one frame is 12 clocks.
module tb_keypad_debounce_scan;

    logic       clk;
    logic       rst;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [11:0] pressed;

    int checks;
    int failures;
    int pulses;
    int first_pulse;
    logic [3:0] pulse_code;
    logic       pulse_held;
    logic       prev_valid;
    logic       double_pulse;

    keypad_debounce_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix: bit r*3+c closes row r onto column c.
    assign key_row[0] = |(pressed[2:0]  & key_col);
    assign key_row[1] = |(pressed[5:3]  & key_col);
    assign key_row[2] = |(pressed[8:6]  & key_col);
    assign key_row[3] = |(pressed[11:9] & key_col);

    function automatic logic [11:0] key_mask(input int r, input int c);
        logic [11:0] m;
        m = '0;
        m[r*3+c] = 1'b1;
        return m;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frames(input int n);
        pulses      = 0;
        first_pulse = 0;
        for (int i = 1; i <= n * 12; i++) begin
            tick();
            if (key_valid) begin
                pulses++;
                if (first_pulse == 0) begin
                    first_pulse = i;
                    pulse_code  = key_code;
                    pulse_held  = key_held;
                end
                if (prev_valid) double_pulse = 1'b1;
            end
            prev_valid = key_valid;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pressed = '0;
        repeat (2) tick();
        if (key_col !== 3'b001) begin failures++; $display("[TB] FAIL reset_col: got %b expected 001", key_col); end
        checks++;
        if (key_code !== 4'd0) begin failures++; $display("[TB] FAIL reset_code: got %0d expected 0", key_code); end
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); end
        checks++;
        if (key_held !== 1'b0) begin failures++; $display("[TB] FAIL reset_held: got %b expected 0", key_held); end
        checks++;
        rst = 1'b0;
    endtask

    task automatic test_scan;
        logic [2:0] exp_col;
        int seen_valid;
        seen_valid = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            case ((t / 4) % 3)
                0:       exp_col = 3'b001;
                1:       exp_col = 3'b010;
                default: exp_col = 3'b100;
            endcase
            if (key_col !== exp_col) begin failures++; $display("[TB] FAIL scan_col t=%0d: got %b expected %b", t, key_col, exp_col); end
            checks++;
            if (key_valid) seen_valid++;
        end
        if (seen_valid !== 0) begin failures++; $display("[TB] FAIL scan_no_valid: got %0d pulses expected 0", seen_valid); end
        checks++;
    endtask

    task automatic test_bounce;
        int total;
        pressed = key_mask(1, 1);
        run_frames(2);
        total = pulses;
        pressed = '0;
        run_frames(1);
        total += pulses;
        pressed = key_mask(1, 1);
        run_frames(2);
        total += pulses;
        pressed = '0;
        run_frames(1);
        total += pulses;
        if (total !== 0) begin failures++; $display("[TB] FAIL bounce_pulses: got %0d expected 0", total); end
        checks++;
        if (key_code !== 4'd0) begin failures++; $display("[TB] FAIL bounce_code: got %0d expected 0", key_code); end
        checks++;
    endtask

    task automatic test_ghost;
        pressed = key_mask(0, 0) | key_mask(1, 0);
        run_frames(6);
        if (pulses !== 0) begin failures++; $display("[TB] FAIL ghost_pulses: got %0d expected 0", pulses); end
        checks++;
        if (key_held !== 1'b0) begin failures++; $display("[TB] FAIL ghost_held: got %b expected 0", key_held); end
        checks++;
        if (key_code !== 4'd0) begin failures++; $display("[TB] FAIL ghost_code: got %0d expected 0", key_code); end
        checks++;
        pressed = '0;
        run_frames(1);
    endtask

    task automatic test_press;
        pressed = key_mask(1, 2);
        run_frames(5);
        if (pulses !== 1) begin failures++; $display("[TB] FAIL press_pulses: got %0d expected 1", pulses); end
        checks++;
        if (first_pulse !== 36) begin failures++; $display("[TB] FAIL press_latency: got %0d expected 36", first_pulse); end
        checks++;
        if (pulse_code !== 4'd6) begin failures++; $display("[TB] FAIL press_pulse_code: got %0d expected 6", pulse_code); end
        checks++;
        if (pulse_held !== 1'b1) begin failures++; $display("[TB] FAIL press_held_at_pulse: got %b expected 1", pulse_held); end
        checks++;
        if (key_code !== 4'd6) begin failures++; $display("[TB] FAIL press_code: got %0d expected 6", key_code); end
        checks++;
        if (key_held !== 1'b1) begin failures++; $display("[TB] FAIL press_held: got %b expected 1", key_held); end
        checks++;
    endtask

    task automatic test_release;
        pressed = '0;
        run_frames(2);
        if (key_held !== 1'b1) begin failures++; $display("[TB] FAIL release_partial_held: got %b expected 1", key_held); end
        checks++;
        pressed = key_mask(1, 2);
        run_frames(1);
        if (pulses !== 0) begin failures++; $display("[TB] FAIL rebounce_pulses: got %0d expected 0", pulses); end
        checks++;
        if (key_held !== 1'b1) begin failures++; $display("[TB] FAIL rebounce_held: got %b expected 1", key_held); end
        checks++;
        pressed = '0;
        run_frames(2);
        if (key_held !== 1'b1) begin failures++; $display("[TB] FAIL release_2frames_held: got %b expected 1", key_held); end
        checks++;
        run_frames(1);
        if (key_held !== 1'b0) begin failures++; $display("[TB] FAIL release_held: got %b expected 0", key_held); end
        checks++;
        pressed = key_mask(3, 1);
        run_frames(3);
        if (pulses !== 1) begin failures++; $display("[TB] FAIL zero_pulses: got %0d expected 1", pulses); end
        checks++;
        if (first_pulse !== 36) begin failures++; $display("[TB] FAIL zero_latency: got %0d expected 36", first_pulse); end
        checks++;
        if (pulse_code !== 4'd0) begin failures++; $display("[TB] FAIL zero_code: got %0d expected 0", pulse_code); end
        checks++;
        pressed = '0;
        run_frames(3);
        if (key_held !== 1'b0) begin failures++; $display("[TB] FAIL zero_release_held: got %b expected 0", key_held); end
        checks++;
    endtask

    task automatic test_reset_mid;
        int early;
        pressed = key_mask(2, 2);
        run_frames(2);
        early = pulses;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (key_valid) early++;
        end
        #2;
        rst = 1'b1;
        #1;
        if (key_col !== 3'b001) begin failures++; $display("[TB] FAIL midrst_col: got %b expected 001", key_col); end
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid: got %b expected 0", key_valid); end
        checks++;
        if (key_held !== 1'b0) begin failures++; $display("[TB] FAIL midrst_held: got %b expected 0", key_held); end
        checks++;
        if (key_code !== 4'd0) begin failures++; $display("[TB] FAIL midrst_code: got %0d expected 0", key_code); end
        checks++;
        tick();
        if (key_valid) early++;
        if (early !== 0) begin failures++; $display("[TB] FAIL midrst_early_pulses: got %0d expected 0", early); end
        checks++;
        rst = 1'b0;
        prev_valid = 1'b0;
        run_frames(3);
        if (pulses !== 1) begin failures++; $display("[TB] FAIL nine_pulses: got %0d expected 1", pulses); end
        checks++;
        if (first_pulse !== 36) begin failures++; $display("[TB] FAIL nine_latency: got %0d expected 36", first_pulse); end
        checks++;
        if (pulse_code !== 4'd9) begin failures++; $display("[TB] FAIL nine_code: got %0d expected 9", pulse_code); end
        checks++;
        pressed = '0;
    endtask

    task automatic test_back_to_back;
        if (double_pulse !== 1'b0) begin failures++; $display("[TB] FAIL back_to_back_valid: got %b expected 0", double_pulse); end
        checks++;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        prev_valid   = 1'b0;
        double_pulse = 1'b0;
        pulse_code   = '0;
        pulse_held   = 1'b0;
        rst          = 1'b1;
        pressed      = '0;
        test_reset();
        test_scan();
        test_bounce();
        test_ghost();
        test_press();
        test_release();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
